systolic_ctrl: RTL and testbench
================================

Name: systolic_ctrl

Overview:
- Sequencer for the weight-stationary systolic array.
- Handles start/done with the host, loads the ARRAY_SIZE x ARRAY_SIZE weight tile row by row from a weight buffer, streams N activation vectors from an activation buffer, and generates the array enable.
- Tracks pipeline latency and marks valid bottom-row partial sums toward a result sink with valid/ready backpressure.
- Sits between the layer scheduler (host side) and one systolic array instance plus its local buffers.

Parameters:
- ARRAY_SIZE, 4, array rows/columns; weight rows loaded per tile.
- ADDR_WIDTH, 10, address width of weight and activation buffers.
- CNT_WIDTH, 12, width of vector count and internal counters.
- PIPE_LAT, 8, cycles (enabled) from an activation vector entering the array to its partial sums valid at the bottom row; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- cfg_wgt_base  in  ADDR_WIDTH  weight buffer base address; captured on start.
- cfg_act_base  in  ADDR_WIDTH  activation buffer base address; captured on start.
- cfg_num_vec  in  CNT_WIDTH  activation vectors in job; captured on start; 0 legal.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at job end.
- wgt_rd_en  out  1  weight buffer read strobe.
- wgt_rd_addr  out  ADDR_WIDTH  weight read address.
- wgt_row_we  out  1  write weight row into array weight regs; 1 cycle after wgt_rd_en (buffer latency 1).
- wgt_row_idx  out  clog2(ARRAY_SIZE)  row targeted by wgt_row_we.
- act_rd_en  out  1  activation buffer read strobe.
- act_rd_addr  out  ADDR_WIDTH  activation read address.
- act_valid  out  1  activation presented to array this cycle (act_rd_en delayed 1); when low the array is fed zeros.
- array_en  out  1  enable to the systolic array.
- array_clr  out  1  one-cycle synchronous clear of array registers at job start.
- res_valid  out  1  partial_sums at array output belong to a real vector.
- res_ready  in  1  result sink accepts.
- res_idx  out  CNT_WIDTH  index of the vector whose result is presented.

Behaviour:
- Reset: state IDLE. All outputs 0; all counters and captured config 0.
- States: IDLE, CLR, LOAD_W, STREAM, DRAIN, FIN.
- IDLE: start=1 -> capture cfg, busy<=1, go to CLR. start in any other state is ignored.
- CLR: array_clr=1 for exactly one cycle, then LOAD_W.
- LOAD_W:
  - wgt_rd_en=1 for ARRAY_SIZE consecutive cycles, addresses cfg_wgt_base+0..ARRAY_SIZE-1 (modulo 2^ADDR_WIDTH wrap).
  - wgt_row_we follows 1 cycle later with wgt_row_idx=0..ARRAY_SIZE-1.
  - Leave after the last wgt_row_we: to STREAM if num_vec>0, else FIN.
- Stall: stall = res_valid & ~res_ready. During STREAM/DRAIN, array_en = ~stall. act_rd_en and all counters advance only when not stalled. act_valid/act data are held during a stall.
- STREAM:
  - act_rd_en=1 each non-stalled cycle, addr cfg_act_base+k, k=0..num_vec-1 (wrap modulo 2^ADDR_WIDTH).
  - After issuing k=num_vec-1, go to DRAIN.
- Latency tracking:
  - A vector presented (act_valid=1) on enabled cycle t yields res_valid on the enabled cycle PIPE_LAT later.
  - Implement with a PIPE_LAT-deep valid shift register advanced only on array_en.
  - res_idx increments on each res_valid & res_ready.
- DRAIN: array_en continues (subject to stall) with act_valid=0 until the res_valid&res_ready handshake for index num_vec-1, then FIN.
- FIN: done=1 one cycle, busy<=0, array_en=0, go to IDLE. Next start is accepted in IDLE the following cycle.
- Exactly num_vec res handshakes per job, in order 0..num_vec-1; no res_valid outside STREAM/DRAIN.
- rst mid-job: return to IDLE next cycle, all outputs 0, no done pulse, valid pipeline flushed.

Test Plan:
- Reset then idle 5 cycles -> busy, done, all strobes, array_en 0.
- start, wgt_base=0x10, act_base=0x20, num_vec=3, PIPE_LAT=8, res_ready=1:
  - CLR 1 cycle.
  - wgt_rd_addr 0x10..0x13.
  - wgt_row_we rows 0..3 each one cycle after reads.
  - act_rd_addr 0x20..0x22.
  - res_valid 3 cycles, idx 0..2, first exactly 8 enabled cycles after first act_valid.
  - done once; busy drops the same cycle.
- Same job with res_ready low for 4 cycles while idx 1 is valid -> array_en, act_rd_en and counters frozen 4 cycles; idx 1 held stable; total cycles +4; results still 0..2.
- num_vec=0 -> CLR, LOAD_W (4 weight reads), FIN; no act_rd_en, no res_valid, done pulses.
- act_base=0x3FE, num_vec=4 (ADDR_WIDTH=10) -> addresses 0x3FE, 0x3FF, 0x000, 0x001. Also: start asserted while busy is ignored and config is unchanged.
- rst asserted during STREAM after 2 vectors -> next cycle IDLE, all outputs 0, no done. A fresh start then completes normally.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencer for one weight-stationary systolic array. It clears the array,
// loads the weight tile row by row, streams the activation vectors, and
// tracks the array pipeline latency so that each bottom-row result is handed
// to the result sink in order, with valid/ready backpressure.
module systolic_ctrl #(
  parameter  int ARRAY_SIZE = 4,
  parameter  int ADDR_WIDTH = 10,
  parameter  int CNT_WIDTH  = 12,
  parameter  int PIPE_LAT   = 8,
  localparam int IDX_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_wgt_base,
  input  logic [ADDR_WIDTH-1:0] cfg_act_base,
  input  logic [CNT_WIDTH-1:0]  cfg_num_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  wgt_rd_en,
  output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
  output logic                  wgt_row_we,
  output logic [IDX_W-1:0]      wgt_row_idx,
  output logic                  act_rd_en,
  output logic [ADDR_WIDTH-1:0] act_rd_addr,
  output logic                  act_valid,
  output logic                  array_en,
  output logic                  array_clr,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_WIDTH-1:0]  res_idx
);

  // Counter wide enough to hold ARRAY_SIZE itself: the extra value marks the
  // cycle in which only the last delayed row write is still in flight.
  localparam int WCNT_W = $clog2(ARRAY_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wgt_base_q, wgt_base_d;
  logic [ADDR_WIDTH-1:0] act_base_q, act_base_d;
  logic [CNT_WIDTH-1:0]  num_vec_q, num_vec_d;
  logic                  busy_q, busy_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0]  kcnt_q, kcnt_d;
  logic [CNT_WIDTH-1:0]  res_idx_q, res_idx_d;
  logic                  act_valid_q;
  logic                  row_we_q;
  logic [IDX_W-1:0]      row_idx_q;
  // Bit i set means a real vector is i+1 enabled cycles into the array.
  logic [PIPE_LAT-1:0]   vpipe_q;

  logic                  in_run;
  logic                  stall;
  logic                  handshake;
  logic [CNT_WIDTH-1:0]  last_vec;

  assign in_run    = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign res_valid = in_run & vpipe_q[PIPE_LAT-1];
  assign stall     = res_valid & ~res_ready;
  assign handshake = res_valid & res_ready;
  assign last_vec  = num_vec_q - CNT_WIDTH'(1);

  assign busy        = busy_q;
  assign wgt_row_we  = row_we_q;
  assign wgt_row_idx = row_idx_q;
  assign act_valid   = act_valid_q;
  assign res_idx     = res_idx_q;
  // Addresses are forced to zero whenever their strobe is low.
  assign wgt_rd_addr = wgt_rd_en ? (wgt_base_q + ADDR_WIDTH'(wcnt_q)) : '0;
  assign act_rd_addr = act_rd_en ? (act_base_q + ADDR_WIDTH'(kcnt_q)) : '0;

  // Next-state, counter updates and per-state strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    wgt_base_d = wgt_base_q;
    act_base_d = act_base_q;
    num_vec_d  = num_vec_q;
    busy_d     = busy_q;
    wcnt_d     = wcnt_q;
    kcnt_d     = kcnt_q;
    res_idx_d  = res_idx_q;
    wgt_rd_en  = 1'b0;
    act_rd_en  = 1'b0;
    array_en   = 1'b0;
    array_clr  = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wgt_base_d = cfg_wgt_base;
          act_base_d = cfg_act_base;
          num_vec_d  = cfg_num_vec;
          busy_d     = 1'b1;
          wcnt_d     = '0;
          kcnt_d     = '0;
          res_idx_d  = '0;
          state_d    = S_CLR;
        end
      end

      S_CLR: begin
        array_clr = 1'b1;
        state_d   = S_LOAD_W;
      end

      S_LOAD_W: begin
        if (wcnt_q < WCNT_W'(ARRAY_SIZE)) begin
          wgt_rd_en = 1'b1;
          wcnt_d    = wcnt_q + WCNT_W'(1);
        end else begin
          // The last row write is on the port this cycle.
          if (num_vec_q != '0) begin
            state_d = S_STREAM;
          end else begin
            busy_d  = 1'b0;
            state_d = S_FIN;
          end
        end
      end

      S_STREAM: begin
        array_en = ~stall;
        if (!stall) begin
          act_rd_en = 1'b1;
          kcnt_d    = kcnt_q + CNT_WIDTH'(1);
          if (kcnt_q == last_vec) begin
            state_d = S_DRAIN;
          end
        end
        if (handshake) begin
          res_idx_d = res_idx_q + CNT_WIDTH'(1);
        end
      end

      S_DRAIN: begin
        array_en = ~stall;
        if (handshake) begin
          if (res_idx_q == last_vec) begin
            res_idx_d = '0;
            busy_d    = 1'b0;
            state_d   = S_FIN;
          end else begin
            res_idx_d = res_idx_q + CNT_WIDTH'(1);
          end
        end
      end

      S_FIN: begin
        done    = 1'b1;
        kcnt_d  = '0;
        wcnt_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, captured config, counters and the delayed strobes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs before any of them update in the same edge.
    if (rst) begin
      state_q     <= S_IDLE;
      wgt_base_q  <= '0;
      act_base_q  <= '0;
      num_vec_q   <= '0;
      busy_q      <= 1'b0;
      wcnt_q      <= '0;
      kcnt_q      <= '0;
      res_idx_q   <= '0;
      act_valid_q <= 1'b0;
      row_we_q    <= 1'b0;
      row_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      wgt_base_q <= wgt_base_d;
      act_base_q <= act_base_d;
      num_vec_q  <= num_vec_d;
      busy_q     <= busy_d;
      wcnt_q     <= wcnt_d;
      kcnt_q     <= kcnt_d;
      res_idx_q  <= res_idx_d;
      // Weight buffer has one cycle of read latency.
      row_we_q   <= wgt_rd_en;
      row_idx_q  <= wgt_rd_en ? wcnt_q[IDX_W-1:0] : '0;
      // The activation word presented to the array is held during a stall.
      if (!stall) begin
        act_valid_q <= act_rd_en;
      end
    end
  end

  // Valid tracker: moves in lockstep with the array, frozen while it is.
  always_ff @(posedge clk) begin
    // NOTE: this shift register is reset (unlike a data buffer would be)
    // because stale valid bits after an aborted job would emit phantom results.
    if (rst || state_q == S_CLR) begin
      vpipe_q <= '0;
    end else if (array_en) begin
      vpipe_q <= PIPE_LAT'({vpipe_q, act_valid_q});
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a stimulus process pushes the expected read
// addresses, row indices and result order into queues when it launches a
// job; a monitor sampling on the falling edge pops and compares them.
module tb_systolic_ctrl;

  localparam int AS = 4;
  localparam int AW = 10;
  localparam int CW = 12;
  localparam int PL = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_wgt_base;
  logic [AW-1:0] cfg_act_base;
  logic [CW-1:0] cfg_num_vec;
  logic          busy;
  logic          done;
  logic          wgt_rd_en;
  logic [AW-1:0] wgt_rd_addr;
  logic          wgt_row_we;
  logic [IW-1:0] wgt_row_idx;
  logic          act_rd_en;
  logic [AW-1:0] act_rd_addr;
  logic          act_valid;
  logic          array_en;
  logic          array_clr;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_idx;

  systolic_ctrl #(
    .ARRAY_SIZE(AS),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW),
    .PIPE_LAT  (PL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_wgt_base(cfg_wgt_base),
    .cfg_act_base(cfg_act_base),
    .cfg_num_vec (cfg_num_vec),
    .busy        (busy),
    .done        (done),
    .wgt_rd_en   (wgt_rd_en),
    .wgt_rd_addr (wgt_rd_addr),
    .wgt_row_we  (wgt_row_we),
    .wgt_row_idx (wgt_row_idx),
    .act_rd_en   (act_rd_en),
    .act_rd_addr (act_rd_addr),
    .act_valid   (act_valid),
    .array_en    (array_en),
    .array_clr   (array_clr),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_idx     (res_idx)
  );

  always #5 clk = ~clk;

  logic [63:0] all_out;
  assign all_out = {21'd0, busy, done, wgt_rd_en, wgt_rd_addr, wgt_row_we, wgt_row_idx,
                    act_rd_en, act_rd_addr, act_valid, array_en, array_clr,
                    res_valid, res_idx};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard queues, filled by stimulus, drained by the monitor.
  logic [AW-1:0] q_wgt[$];
  logic [AW-1:0] q_act[$];
  int            q_row[$];
  int            q_res[$];
  int            pres_e[$];   // enabled-cycle ordinal at which each vector entered

  int ecnt      = 0;          // enabled array cycles seen so far
  int cyc       = 0;
  int done_cnt  = 0;
  int clr_cnt   = 0;
  int hs_cnt    = 0;
  int act_cnt   = 0;
  int stall_cyc = 0;
  int done_cyc  = 0;
  int clr_cyc   = 0;
  int last_idx  = -1;

  int rdy_mode    = 0;        // 0: always ready, 1: random, 2: one 4-cycle stall on idx 1
  bit stall_armed = 1'b0;
  int last_stall  = 0;

  // Monitor: compares every observable event against the queued expectations.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q_wgt.delete();
      q_act.delete();
      q_row.delete();
      q_res.delete();
      pres_e.delete();
    end else begin
      if (array_clr) begin
        clr_cnt++;
        clr_cyc  = cyc;
        last_idx = -1;
        pres_e.delete();
        check("busy_in_clr", busy, 1);
      end
      if (wgt_rd_en) begin
        if (q_wgt.size() == 0) check("wgt_rd_extra", 1, 0);
        else check("wgt_rd_addr", wgt_rd_addr, q_wgt.pop_front());
      end
      if (wgt_row_we) begin
        if (q_row.size() == 0) check("wgt_row_extra", 1, 0);
        else check("wgt_row_idx", wgt_row_idx, q_row.pop_front());
      end
      if (act_rd_en) begin
        act_cnt++;
        if (q_act.size() == 0) check("act_rd_extra", 1, 0);
        else check("act_rd_addr", act_rd_addr, q_act.pop_front());
      end
      if (res_valid) begin
        check("res_valid_only_while_busy", busy, 1);
        if (int'(res_idx) != last_idx) begin
          last_idx = int'(res_idx);
          if (pres_e.size() == 0) check("res_without_vector", 1, 0);
          else check("latency_enabled_cycles", ecnt - pres_e.pop_front(), PL);
        end
        if (q_res.size() == 0) begin
          check("res_extra", 1, 0);
        end else if (res_ready) begin
          hs_cnt++;
          check("res_idx", res_idx, q_res.pop_front());
        end else begin
          stall_cyc++;
          check("res_idx_held", res_idx, q_res[0]);
          check("frozen_on_stall", {array_en, act_rd_en}, 0);
        end
      end
      if (array_en && act_valid) pres_e.push_back(ecnt);
      if (array_en) ecnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  // Result sink ready driver.
  initial begin
    int hold;
    hold      = 0;
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: res_ready = 1'b1;
        1: res_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (hold > 0) begin
            hold--;
            if (hold == 0) res_ready = 1'b1;
          end else if (stall_armed && res_valid && res_idx == CW'(1)) begin
            res_ready   = 1'b0;
            hold        = 4;
            stall_armed = 1'b0;
          end else begin
            res_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic push_job(input logic [AW-1:0] wb, input logic [AW-1:0] ab, input int n);
    for (int i = 0; i < AS; i++) begin
      q_wgt.push_back(wb + AW'(i));
      q_row.push_back(i);
    end
    for (int k = 0; k < n; k++) begin
      q_act.push_back(ab + AW'(k));
      q_res.push_back(k);
    end
  endtask

  task automatic issue_start(input logic [AW-1:0] wb, input logic [AW-1:0] ab, input int n);
    @(posedge clk);
    #1;
    start        = 1'b1;
    cfg_wgt_base = wb;
    cfg_act_base = ab;
    cfg_num_vec  = CW'(n);
    @(posedge clk);
    #1;
    start        = 1'b0;
    cfg_wgt_base = AW'($urandom);
    cfg_act_base = AW'($urandom);
    cfg_num_vec  = CW'($urandom);
  endtask

  task automatic run_job(input logic [AW-1:0] wb, input logic [AW-1:0] ab, input int n,
                         input int mode, input bit poke, output int cycles);
    int d0, c0, h0, a0, s0;
    bit ok;
    rdy_mode    = mode;
    stall_armed = 1'b1;
    d0 = done_cnt; c0 = clr_cnt; h0 = hs_cnt; a0 = act_cnt; s0 = stall_cyc;
    push_job(wb, ab, n);
    issue_start(wb, ab, n);
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      start        = 1'b1;
      cfg_wgt_base = 10'h155;
      cfg_act_base = 10'h0AA;
      cfg_num_vec  = CW'(9);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_within_bound", ok, 1);
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 0;
    check("done_once", done_cnt - d0, 1);
    check("clr_once", clr_cnt - c0, 1);
    check("handshake_count", hs_cnt - h0, n);
    check("act_read_count", act_cnt - a0, n);
    check("queues_drained", q_wgt.size() + q_row.size() + q_act.size() + q_res.size(), 0);
    check("idle_after_job", busy, 0);
    cycles     = done_cyc - clr_cyc;
    last_stall = stall_cyc - s0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_cyc, stall_job_cyc, c, d0, a0;
    bit ok;
    rst          = 1'b1;
    start        = 1'b0;
    cfg_wgt_base = '0;
    cfg_act_base = '0;
    cfg_num_vec  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_outputs_zero", all_out, 0);
    end

    // Directed jobs.
    run_job(10'h010, 10'h020, 3, 0, 1'b0, base_cyc);
    run_job(10'h010, 10'h020, 3, 2, 1'b0, stall_job_cyc);
    check("stall_cycles_seen", last_stall, 4);
    check("stall_adds_4_cycles", stall_job_cyc - base_cyc, 4);
    run_job(10'h100, 10'h200, 0, 0, 1'b0, c);
    run_job(10'h3FD, 10'h3FE, 4, 0, 1'b1, c);

    // Reset in the middle of streaming.
    d0 = done_cnt;
    a0 = act_cnt;
    push_job(10'h040, 10'h080, 6);
    issue_start(10'h040, 10'h080, 6);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (act_cnt - a0 >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("reached_stream", ok, 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("outputs_zero_after_rst", all_out, 0);
    check("no_done_on_rst", done_cnt - d0, 0);
    repeat (3) @(negedge clk);
    check("still_idle_after_rst", all_out, 0);
    run_job(10'h010, 10'h020, 3, 0, 1'b0, c);
    check("fresh_job_cycles", c, base_cyc);

    // Randomised jobs with random backpressure.
    for (int j = 0; j < 8; j++) begin
      run_job(AW'($urandom), AW'($urandom), $urandom_range(0, 12), 1, 1'b0, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
